imem_row_server: RTL and testbench

- Input-memory responder at network node IMEM_ID (10) for the partial-PE array.
- Stores the binary input feature map for each timestep, one 25-bit row per word.
- At timestep start, pushes each partial PE its first input row. It then serves each PE's "more inputs" request with that PE's next row.
- After the controller signals the end of a timestep, broadcasts TIMESTEP_DONE to every PE and advances to the next timestep.
- Output feeds the packetizer: dest / opcode / data fields.

---
 rtl/ppe_pkg.sv | 21 ++
 rtl/imem_row_ram.sv | 32 +++
 rtl/imem_row_server.sv | 267 ++++++++++++++++++++++++++
 tb/tb_imem_row_server.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppe_pkg.sv
// rtl/ppe_pkg.sv - shared packet fields, opcodes and server state encoding
package ppe_pkg;

   localparam int ADDR_W   = 4;
   localparam int OPCODE_W = 4;
   localparam int DATA_W   = 25;

   localparam logic [OPCODE_W-1:0] OP_WEIGHT        = 4'd0;
   localparam logic [OPCODE_W-1:0] OP_INPUT         = 4'd1;
   localparam logic [OPCODE_W-1:0] OP_TIMESTEP_DONE = 4'd15;
   localparam logic [ADDR_W-1:0]   IMEM_ID          = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_SERVE,
      ST_BCAST,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/imem_row_ram.sv
// rtl/imem_row_ram.sv - row storage, synchronous write, registered read
module imem_row_ram #(
   parameter int DEPTH = 50,
   parameter int WIDTH = 25,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   // Read register holds its value while a packet is stalled downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_rd_data <= '0;
      else if (rd_en) r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/imem_row_server.sv
// rtl/imem_row_server.sv - input-memory row server for the partial-PE array
module imem_row_server
   import ppe_pkg::*;
#(
   parameter int NUM_PE      = 5,
   parameter int ROWS_PER_PE = 5,
   parameter int ROW_WIDTH   = DATA_W,
   parameter int NUM_ROWS    = 25,
   parameter int NUM_TS      = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ld_valid,
   output logic                        ld_ready,
   input  logic [$clog2(NUM_TS)-1:0]   ld_ts,
   input  logic [$clog2(NUM_ROWS)-1:0] ld_row,
   input  logic [ROW_WIDTH-1:0]        ld_data,
   input  logic                        start,
   input  logic                        ts_advance,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_W-1:0]           req_pe,
   output logic                        pkt_valid,
   input  logic                        pkt_ready,
   output logic [ADDR_W-1:0]           pkt_dest,
   output logic [OPCODE_W-1:0]         pkt_opcode,
   output logic [ROW_WIDTH-1:0]        pkt_data,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   localparam int AW  = $clog2(NUM_TS * NUM_ROWS);
   localparam int CW  = $clog2(ROWS_PER_PE + 1);
   localparam int KW  = $clog2(NUM_PE + 1);
   localparam int TW  = $clog2(NUM_TS);
   localparam int LRW = $clog2(NUM_ROWS);

   state_t                r_state, w_state_next;
   logic [TW-1:0]         r_ts;
   logic [KW-1:0]         r_k, w_k_next;
   logic [KW-1:0]         r_rr_ptr;
   logic [CW-1:0]         r_sent_cnt [NUM_PE];
   logic [NUM_PE-1:0]     r_pending;
   logic                  r_pkt_valid;
   logic [ADDR_W-1:0]     r_pkt_dest;
   logic [OPCODE_W-1:0]   r_pkt_opcode;
   logic                  r_err;

   logic                  w_slot_free, w_all_sent;
   logic                  w_rr_any, w_hi_found;
   logic [KW-1:0]         w_rr_low, w_rr_hi, w_rr_sel;
   logic [CW-1:0]         w_sel_cnt;
   logic                  w_issue, w_rd_en, w_serve, w_prime_issue;
   logic                  w_adv_ok, w_clear_ts, w_ts_inc;
   logic [KW-1:0]         w_issue_pe;
   logic [OPCODE_W-1:0]   w_issue_op;
   logic [CW-1:0]         w_row_n;
   logic [NUM_PE-1:0]     w_req_oh;
   logic                  w_req_bad;
   logic                  w_ld_fire, w_ld_bad;
   logic [AW-1:0]         w_wr_addr, w_rd_addr;
   logic [ROW_WIDTH-1:0]  w_rd_data;

   assign w_slot_free = !r_pkt_valid || pkt_ready;
   assign w_ld_fire   = ld_valid && (r_state == ST_IDLE);
   assign w_ld_bad    = w_ld_fire && ({1'b0, ld_row} >= (LRW + 1)'(NUM_ROWS));
   assign w_wr_addr   = AW'(ld_ts) * AW'(NUM_ROWS) + AW'(ld_row);
   assign w_rd_addr   = AW'(r_ts) * AW'(NUM_ROWS) + AW'(w_issue_pe) * AW'(ROWS_PER_PE) + AW'(w_row_n);

   imem_row_ram #(
      .DEPTH (NUM_TS * NUM_ROWS),
      .WIDTH (ROW_WIDTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_ld_fire && !w_ld_bad),
      .wr_addr (w_wr_addr),
      .wr_data (ld_data),
      .rd_en   (w_rd_en),
      .rd_addr (w_rd_addr),
      .rd_data (w_rd_data)
   );

   // Round-robin: lowest pending index at or above rr_ptr, else lowest overall
   always_comb begin
      w_rr_any   = 1'b0;
      w_hi_found = 1'b0;
      w_rr_low   = '0;
      w_rr_hi    = '0;
      for (int k = NUM_PE - 1; k >= 0; k--) begin
         if (r_pending[k]) begin
            w_rr_any = 1'b1;
            w_rr_low = KW'(k);
            if (KW'(k) >= r_rr_ptr) begin
               w_hi_found = 1'b1;
               w_rr_hi    = KW'(k);
            end
         end
      end
      w_rr_sel  = w_hi_found ? w_rr_hi : w_rr_low;
      w_sel_cnt = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         if (w_rr_sel == KW'(k)) w_sel_cnt = r_sent_cnt[k];
      end
   end

   always_comb begin
      w_all_sent = 1'b1;
      for (int k = 0; k < NUM_PE; k++) begin
         if (r_sent_cnt[k] != CW'(ROWS_PER_PE)) w_all_sent = 1'b0;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_k_next      = r_k;
      w_issue       = 1'b0;
      w_issue_pe    = '0;
      w_issue_op    = '0;
      w_row_n       = '0;
      w_rd_en       = 1'b0;
      w_serve       = 1'b0;
      w_prime_issue = 1'b0;
      w_adv_ok      = 1'b0;
      w_clear_ts    = 1'b0;
      w_ts_inc      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_PRIME;
               w_k_next     = '0;
            end
         end
         ST_PRIME: begin
            if (w_slot_free) begin
               if (r_k < KW'(NUM_PE)) begin
                  w_issue       = 1'b1;
                  w_prime_issue = 1'b1;
                  w_issue_pe    = r_k;
                  w_issue_op    = OP_INPUT;
                  w_rd_en       = 1'b1;
                  w_k_next      = r_k + 1'b1;
               end else begin
                  w_state_next = ST_SERVE;
               end
            end
         end
         ST_SERVE: begin
            if (ts_advance && w_all_sent && !r_pkt_valid) begin
               w_adv_ok     = 1'b1;
               w_state_next = ST_BCAST;
               w_k_next     = '0;
            end else if (w_slot_free && w_rr_any) begin
               w_issue    = 1'b1;
               w_serve    = 1'b1;
               w_issue_pe = w_rr_sel;
               w_issue_op = OP_INPUT;
               w_row_n    = w_sel_cnt;
               w_rd_en    = 1'b1;
            end
         end
         ST_BCAST: begin
            if (w_slot_free) begin
               if (r_k < KW'(NUM_PE)) begin
                  w_issue    = 1'b1;
                  w_issue_pe = r_k;
                  w_issue_op = OP_TIMESTEP_DONE;
                  w_k_next   = r_k + 1'b1;
               end else begin
                  w_clear_ts = 1'b1;
                  if (r_ts != TW'(NUM_TS - 1)) begin
                     w_ts_inc     = 1'b1;
                     w_k_next     = '0;
                     w_state_next = ST_PRIME;
                  end else begin
                     w_state_next = ST_FINISH;
                  end
               end
            end
         end
         ST_FINISH: ;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // A request from the PE being served this cycle is judged against its post-serve state
   always_comb begin
      w_req_oh  = '0;
      w_req_bad = 1'b0;
      if (req_valid) begin
         if (r_state == ST_IDLE || r_state == ST_BCAST || r_state == ST_FINISH ||
             req_pe >= ADDR_W'(NUM_PE)) begin
            w_req_bad = 1'b1;
         end else begin
            for (int k = 0; k < NUM_PE; k++) begin
               if (req_pe == ADDR_W'(k)) begin
                  if (w_serve && w_rr_sel == KW'(k)) begin
                     if (r_sent_cnt[k] + 1'b1 == CW'(ROWS_PER_PE)) w_req_bad = 1'b1;
                     else                                          w_req_oh[k] = 1'b1;
                  end else if (r_pending[k] || r_sent_cnt[k] == CW'(ROWS_PER_PE)) begin
                     w_req_bad = 1'b1;
                  end else begin
                     w_req_oh[k] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts         <= '0;
         r_k          <= '0;
         r_rr_ptr     <= '0;
         r_pending    <= '0;
         r_pkt_valid  <= 1'b0;
         r_pkt_dest   <= '0;
         r_pkt_opcode <= '0;
         r_err        <= 1'b0;
         for (int k = 0; k < NUM_PE; k++) r_sent_cnt[k] <= '0;
      end else begin
         r_k <= w_k_next;
         if (w_ts_inc) r_ts <= r_ts + 1'b1;
         if (w_issue) begin
            r_pkt_valid  <= 1'b1;
            r_pkt_dest   <= ADDR_W'(w_issue_pe);
            r_pkt_opcode <= w_issue_op;
         end else if (pkt_ready) begin
            r_pkt_valid  <= 1'b0;
         end
         if (w_serve) r_rr_ptr <= (w_rr_sel == KW'(NUM_PE - 1)) ? '0 : w_rr_sel + 1'b1;
         for (int k = 0; k < NUM_PE; k++) begin
            if (w_clear_ts) begin
               r_sent_cnt[k] <= '0;
               r_pending[k]  <= 1'b0;
            end else begin
               if (w_prime_issue && r_k == KW'(k))
                  r_sent_cnt[k] <= CW'(1);
               else if (w_serve && w_rr_sel == KW'(k) && r_sent_cnt[k] != CW'(ROWS_PER_PE))
                  r_sent_cnt[k] <= r_sent_cnt[k] + 1'b1;
               if (w_req_oh[k])                        r_pending[k] <= 1'b1;
               else if (w_serve && w_rr_sel == KW'(k)) r_pending[k] <= 1'b0;
            end
         end
         if (w_ld_bad || w_req_bad || (ts_advance && !w_adv_ok)) r_err <= 1'b1;
      end
   end

   assign ld_ready   = (r_state == ST_IDLE);
   assign req_ready  = rst_n;
   assign busy       = (r_state != ST_IDLE) && (r_state != ST_FINISH);
   assign done       = (r_state == ST_FINISH);
   assign err        = r_err;
   assign pkt_valid  = r_pkt_valid;
   assign pkt_dest   = r_pkt_dest;
   assign pkt_opcode = r_pkt_opcode;
   assign pkt_data   = (r_pkt_opcode == OP_INPUT) ? w_rd_data : '0;

endmodule

// File: tb/tb_imem_row_server.sv
// tb/tb_imem_row_server.sv - directed self-checking bench for imem_row_server
module tb_imem_row_server;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [0:0]  ld_ts = '0;
   logic [4:0]  ld_row = '0;
   logic [24:0] ld_data = '0;
   logic        start = 1'b0;
   logic        ts_advance = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_pe = '0;
   logic        pkt_valid;
   logic        pkt_ready = 1'b1;
   logic [3:0]  pkt_dest;
   logic [3:0]  pkt_opcode;
   logic [24:0] pkt_data;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;
   int exp_cnt [5];

   logic [3:0]  q_dest [$];
   logic [3:0]  q_op   [$];
   logic [24:0] q_data [$];

   imem_row_server dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_ts      (ld_ts),
      .ld_row     (ld_row),
      .ld_data    (ld_data),
      .start      (start),
      .ts_advance (ts_advance),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pe     (req_pe),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_dest   (pkt_dest),
      .pkt_opcode (pkt_opcode),
      .pkt_data   (pkt_data),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so the negedge sees the handshake that completes next
   always @(negedge clk) begin
      if (rst_n && pkt_valid && pkt_ready) begin
         q_dest.push_back(pkt_dest);
         q_op.push_back(pkt_opcode);
         q_data.push_back(pkt_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      q_dest.delete();
      q_op.delete();
      q_data.delete();
      for (int k = 0; k < 5; k++) exp_cnt[k] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; ts_advance = 1'b0; req_valid = 1'b0; ld_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_advance();
      ts_advance = 1'b1; tick(); ts_advance = 1'b0;
   endtask

   task automatic send_req(input int pe);
      req_valid = 1'b1; req_pe = 4'(pe); tick(); req_valid = 1'b0;
   endtask

   task automatic get_pkt(output bit got, output logic [3:0] d, output logic [3:0] o, output logic [24:0] v);
      int n = 0;
      got = 1'b0; d = '0; o = '0; v = '0;
      while (q_data.size() == 0 && n < 60) begin tick(); n++; end
      if (q_data.size() != 0) begin
         got = 1'b1;
         d = q_dest.pop_front();
         o = q_op.pop_front();
         v = q_data.pop_front();
      end
   endtask

   task automatic check_prime(input int bank);
      bit got; logic [3:0] d, o; logic [24:0] v;
      for (int k = 0; k < 5; k++) begin
         get_pkt(got, d, o, v);
         total++;
         if (!got || d !== 4'(k) || o !== 4'd1 || v !== 25'(100 * bank + 5 * k)) begin
            bad++;
            $display("FAIL prime b%0d k%0d: got=%0b dest=%0d op=%0d data=%0d, want dest=%0d op=1 data=%0d",
                     bank, k, got, d, o, v, k, 100 * bank + 5 * k);
         end
         exp_cnt[k] = 1;
      end
   endtask

   task automatic check_serve(input int pe, input int bank);
      bit got; logic [3:0] d, o; logic [24:0] v;
      int want;
      want = 100 * bank + 5 * pe + exp_cnt[pe];
      get_pkt(got, d, o, v);
      total++;
      if (!got || d !== 4'(pe) || o !== 4'd1 || v !== 25'(want)) begin
         bad++;
         $display("FAIL serve pe%0d b%0d: got=%0b dest=%0d op=%0d data=%0d, want dest=%0d op=1 data=%0d",
                  pe, bank, got, d, o, v, pe, want);
      end
      exp_cnt[pe]++;
   endtask

   task automatic serve_rest(input int bank);
      for (int pe = 0; pe < 5; pe++) begin
         while (exp_cnt[pe] < 5) begin
            send_req(pe);
            check_serve(pe, bank);
         end
      end
   endtask

   task automatic check_bcast();
      bit got; logic [3:0] d, o; logic [24:0] v;
      for (int k = 0; k < 5; k++) begin
         get_pkt(got, d, o, v);
         total++;
         if (!got || d !== 4'(k) || o !== 4'd15 || v !== 25'd0) begin
            bad++;
            $display("FAIL bcast k%0d: got=%0b dest=%0d op=%0d data=%0d, want dest=%0d op=15 data=0",
                     k, got, d, o, v, k);
         end
      end
   endtask

   task automatic check_no_pkt(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) tick();
      total++;
      if (q_data.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d unexpected packets, want 0", name, q_data.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      total++;
      if (pkt_valid !== 1'b0 || pkt_dest !== 4'd0 || pkt_opcode !== 4'd0 || pkt_data !== 25'd0) begin
         bad++;
         $display("FAIL reset_pkt: valid=%0b dest=%0d op=%0d data=%0d, want all 0", pkt_valid, pkt_dest, pkt_opcode, pkt_data);
      end
      total++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: done=%0b err=%0b busy=%0b req_ready=%0b, want 0 0 0 0", done, err, busy, req_ready);
      end
      rst_n = 1'b1;
      clear_model();
      tick();
      total++;
      if (ld_ready !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: ld_ready=%0b req_ready=%0b busy=%0b, want 1 1 0", ld_ready, req_ready, busy);
      end
   endtask

   task automatic test_load();
      for (int t = 0; t < 2; t++) begin
         for (int r = 0; r < 25; r++) begin
            ld_valid = 1'b1; ld_ts = 1'(t); ld_row = 5'(r); ld_data = 25'(r + 100 * t);
            tick();
         end
      end
      ld_valid = 1'b0;
      total++;
      if (err !== 1'b0 || ld_ready !== 1'b1) begin
         bad++;
         $display("FAIL load: err=%0b ld_ready=%0b, want 0 1", err, ld_ready);
      end
   endtask

   task automatic test_prime();
      pulse_start();
      total++;
      if (busy !== 1'b1 || ld_ready !== 1'b0) begin
         bad++;
         $display("FAIL prime_busy: busy=%0b ld_ready=%0b, want 1 0", busy, ld_ready);
      end
      check_prime(0);
   endtask

   task automatic test_pe2_serve();
      tick(); tick(); tick();
      send_req(2);
      total++;
      if (pkt_valid !== 1'b0) begin
         bad++;
         $display("FAIL latency_t1: pkt_valid=%0b, want 0", pkt_valid);
      end
      tick();
      total++;
      if (pkt_valid !== 1'b1 || pkt_dest !== 4'd2 || pkt_data !== 25'd11) begin
         bad++;
         $display("FAIL latency_t2: valid=%0b dest=%0d data=%0d, want 1 2 11", pkt_valid, pkt_dest, pkt_data);
      end
      check_serve(2, 0);
      for (int n = 0; n < 3; n++) begin
         send_req(2);
         check_serve(2, 0);
      end
      send_req(2);
      check_no_pkt("pe2_fifth_no_pkt", 6);
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL pe2_fifth_err: err=%0b, want 1", err);
      end
   endtask

   task automatic test_rr_stall();
      int n = 0;
      pkt_ready = 1'b0;
      send_req(4);
      while (pkt_valid !== 1'b1 && n < 20) begin tick(); n++; end
      send_req(3);
      send_req(1);
      for (int c = 0; c < 3; c++) begin
         total++;
         if (pkt_valid !== 1'b1 || pkt_dest !== 4'd4 || pkt_opcode !== 4'd1 || pkt_data !== 25'd21) begin
            bad++;
            $display("FAIL stall_c%0d: valid=%0b dest=%0d op=%0d data=%0d, want 1 4 1 21",
                     c, pkt_valid, pkt_dest, pkt_opcode, pkt_data);
         end
         tick();
      end
      pkt_ready = 1'b1;
      check_serve(4, 0);
      check_serve(1, 0);
      check_serve(3, 0);
   endtask

   task automatic test_ts_advance();
      serve_rest(0);
      tick();
      pulse_advance();
      check_bcast();
      check_prime(1);
      serve_rest(1);
      tick();
      pulse_advance();
      check_bcast();
      tick(); tick(); tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || pkt_valid !== 1'b0) begin
         bad++;
         $display("FAIL finish: done=%0b busy=%0b valid=%0b, want 1 0 0", done, busy, pkt_valid);
      end
   endtask

   task automatic test_early_advance();
      do_reset();
      total++;
      if (err !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL rereset: err=%0b done=%0b, want 0 0", err, done);
      end
      pulse_start();
      check_prime(0);
      for (int r = 0; r < 3; r++) begin
         for (int pe = 0; pe < 5; pe++) begin
            send_req(pe);
            check_serve(pe, 0);
         end
      end
      tick();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL early_pre: err=%0b, want 0", err);
      end
      pulse_advance();
      check_no_pkt("early_no_bcast", 8);
      total++;
      if (err !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL early_err: err=%0b busy=%0b, want 1 1", err, busy);
      end
   endtask

   task automatic test_bad_pe();
      do_reset();
      pulse_start();
      check_prime(0);
      tick(); tick();
      send_req(7);
      check_no_pkt("bad_pe_no_pkt", 6);
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL bad_pe_err: err=%0b, want 1", err);
      end
   endtask

   task automatic test_bad_load();
      do_reset();
      ld_valid = 1'b1; ld_ts = 1'b0; ld_row = 5'd25; ld_data = 25'h1ABCDEF;
      tick();
      ld_valid = 1'b0;
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL bad_load_err: err=%0b, want 1", err);
      end
      do_reset();
      pulse_start();
      check_prime(0);
      serve_rest(0);
      tick();
      pulse_advance();
      check_bcast();
      check_prime(1);
   endtask

   task automatic test_reset_midflight();
      int n = 0;
      do_reset();
      pkt_ready = 1'b0;
      pulse_start();
      while (pkt_valid !== 1'b1 && n < 20) begin tick(); n++; end
      total++;
      if (pkt_valid !== 1'b1 || pkt_dest !== 4'd0) begin
         bad++;
         $display("FAIL midflight_pre: valid=%0b dest=%0d, want 1 0", pkt_valid, pkt_dest);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (pkt_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL midflight_reset: valid=%0b busy=%0b err=%0b, want 0 0 0", pkt_valid, busy, err);
      end
      tick(); tick();
      rst_n = 1'b1;
      clear_model();
      pkt_ready = 1'b1;
      pulse_start();
      check_prime(0);
   endtask

   initial begin
      clear_model();
      test_reset();
      test_load();
      test_prime();
      test_pe2_serve();
      test_rr_stall();
      test_ts_advance();
      test_early_advance();
      test_bad_pe();
      test_bad_load();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
